lbm_field_render: RTL and testbench

// Downstream consumer of the LBM lattice BRAM. On start_in it scans all BRAM_DEPTH lattice points in address order.
// For each point it reads the 9 distributions and computes a macroscopic quantity: density, x/y velocity or speed.

---
 rtl/lbm_field_render.sv | 182 ++++++++++++++++++
 tb/tb_lbm_field_render.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lbm_field_render.sv
// lbm_field_render: scans the LBM lattice BRAM in address order and turns each
// point's nine distributions into an 8-bit intensity (density, ux, uy or speed)
// written to the frame buffer, one point per cycle with a fixed 4-cycle latency.
module lbm_field_render #(
    parameter int GRID_W     = 205,
    parameter int GRID_H     = 154,
    parameter int BRAM_DEPTH = 31570,
    localparam int ADDR_W    = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [1:0]            mode_in,
    input  logic [8:0][7:0]       bram_data_in,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [ADDR_W-1:0]     pixel_addr_out,
    output logic [7:0]            pixel_out,
    output logic                  pixel_valid_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_DEPTH - 1);

    // The lattice geometry and the BRAM depth must describe the same array.
    if (GRID_W * GRID_H != BRAM_DEPTH) begin : g_geom_check
        $error("lbm_field_render: GRID_W*GRID_H must equal BRAM_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_issue;
    logic                  w_accept;
    logic [1:0]            r_mode;

    // Pipeline tracking: valid and address follow each point through the BRAM
    // (stages 1-2) and the sum register (stage 3).
    logic                  r_v1, r_v2, r_v3;
    logic [ADDR_W-1:0]     r_a1, r_a2, r_a3;

    logic [11:0]           w_rho;
    logic [9:0]            w_ux_pos, w_ux_neg, w_uy_pos, w_uy_neg;
    logic signed [10:0]    w_ux, w_uy;
    logic [11:0]           r_rho;
    logic signed [10:0]    r_ux, r_uy;

    logic signed [12:0]    w_ux13, w_uy13;
    logic signed [12:0]    w_abs_ux, w_abs_uy;
    logic signed [12:0]    w_val;
    logic [7:0]            w_pix;

    assign w_accept = (r_state == S_IDLE) && start_in;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_state_next = S_SCAN;
            S_SCAN:  if (addr_out == LAST_ADDR) w_state_next = S_DRAIN;
            S_DRAIN: if (pixel_valid_out && (pixel_addr_out == LAST_ADDR)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_out = 1'b0;
        done_out = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            S_SCAN:  begin busy_out = 1'b1; w_issue = 1'b1; end
            S_DRAIN: busy_out = 1'b1;
            S_DONE:  done_out = 1'b1;
            default: ;
        endcase
    end

    // Address counter and mode latch; address holds at the last point once issued
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_out <= '0;
            r_mode   <= '0;
        end else if (w_accept) begin
            addr_out <= '0;
            r_mode   <= mode_in;
        end else if (w_issue && (addr_out != LAST_ADDR)) begin
            addr_out <= addr_out + 1'b1;
        end
    end

    // Valid/address delay line matching the BRAM latency and the sum stage
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_a1 <= '0;
            r_a2 <= '0;
            r_a3 <= '0;
        end else begin
            r_v1 <= w_issue;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_a1 <= addr_out;
            r_a2 <= r_a1;
            r_a3 <= r_a2;
        end
    end

    // Moment sums of the distributions arriving from the BRAM
    always_comb begin
        w_rho = 12'(bram_data_in[0]) + 12'(bram_data_in[1]) + 12'(bram_data_in[2])
              + 12'(bram_data_in[3]) + 12'(bram_data_in[4]) + 12'(bram_data_in[5])
              + 12'(bram_data_in[6]) + 12'(bram_data_in[7]) + 12'(bram_data_in[8]);
        w_ux_pos = 10'(bram_data_in[2]) + 10'(bram_data_in[3]) + 10'(bram_data_in[4]);
        w_ux_neg = 10'(bram_data_in[6]) + 10'(bram_data_in[7]) + 10'(bram_data_in[8]);
        w_uy_pos = 10'(bram_data_in[1]) + 10'(bram_data_in[2]) + 10'(bram_data_in[8]);
        w_uy_neg = 10'(bram_data_in[4]) + 10'(bram_data_in[5]) + 10'(bram_data_in[6]);
        w_ux = signed'({1'b0, w_ux_pos}) - signed'({1'b0, w_ux_neg});
        w_uy = signed'({1'b0, w_uy_pos}) - signed'({1'b0, w_uy_neg});
    end

    // Sum register stage
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rho <= '0;
            r_ux  <= '0;
            r_uy  <= '0;
        end else begin
            r_rho <= w_rho;
            r_ux  <= w_ux;
            r_uy  <= w_uy;
        end
    end

    // Map the selected quantity to an intensity and clamp to 0..255
    always_comb begin
        w_ux13   = {{2{r_ux[10]}}, r_ux};
        w_uy13   = {{2{r_uy[10]}}, r_uy};
        w_abs_ux = r_ux[10] ? -w_ux13 : w_ux13;
        w_abs_uy = r_uy[10] ? -w_uy13 : w_uy13;
        case (r_mode)
            2'b00:   w_val = signed'({1'b0, 12'(r_rho >> 3)});
            2'b01:   w_val = 13'sd128 + (w_ux13 >>> 2);
            2'b10:   w_val = 13'sd128 + (w_uy13 >>> 2);
            default: w_val = (w_abs_ux + w_abs_uy) >>> 2;
        endcase
        if (w_val < 0)             w_pix = 8'd0;
        else if (w_val > 13'sd255) w_pix = 8'd255;
        else                       w_pix = w_val[7:0];
    end

    // Pixel output register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_valid_out <= 1'b0;
            pixel_addr_out  <= '0;
            pixel_out       <= '0;
        end else begin
            pixel_valid_out <= r_v3;
            if (r_v3) begin
                pixel_addr_out <= r_a3;
                pixel_out      <= w_pix;
            end
        end
    end

endmodule

// File: tb/tb_lbm_field_render.sv
// Directed bench for lbm_field_render: one full default-size scan plus short
// reset-aborted scans probing the arithmetic, clamping and reset behaviour.
module tb_lbm_field_render;

    localparam int DEPTH  = 31570;
    localparam int AW     = $clog2(DEPTH);
    localparam int LAST   = DEPTH - 1;
    localparam int BUDGET = DEPTH + 200;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            start_in;
    logic [1:0]      mode_in;
    logic [8:0][7:0] bram_data_in;
    logic [AW-1:0]   addr_out;
    logic [AW-1:0]   pixel_addr_out;
    logic [7:0]      pixel_out;
    logic            pixel_valid_out;
    logic            busy_out;
    logic            done_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0][7:0] pat;
    logic [8:0][7:0] bram_q1;

    lbm_field_render #(
        .GRID_W     (205),
        .GRID_H     (154),
        .BRAM_DEPTH (DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .mode_in         (mode_in),
        .bram_data_in    (bram_data_in),
        .addr_out        (addr_out),
        .pixel_addr_out  (pixel_addr_out),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Lattice BRAM model: two register stages, every point holds the same pattern
    always @(posedge clk_in) begin
        bram_q1      <= pat;
        bram_data_in <= bram_q1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0][7:0] pat9(input int f0, input int f1, input int f2,
                                              input int f3, input int f4, input int f5,
                                              input int f6, input int f7, input int f8);
        logic [8:0][7:0] p;
        p[0] = 8'(f0); p[1] = 8'(f1); p[2] = 8'(f2);
        p[3] = 8'(f3); p[4] = 8'(f4); p[5] = 8'(f5);
        p[6] = 8'(f6); p[7] = 8'(f7); p[8] = 8'(f8);
        return p;
    endfunction

    // Start a scan on pattern p, check the first pixel and its latency, then abort by reset
    task automatic probe(input string tag, input logic [8:0][7:0] p, input logic [1:0] m,
                         input int exp);
        int k;
        pat     = p;
        mode_in = m;
        repeat (3) @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        mode_in  = ~m;
        k = 0;
        while (!pixel_valid_out && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        chk({tag, "_lat"},  k, 4);
        chk({tag, "_addr"}, int'(pixel_addr_out), 0);
        chk({tag, "_pix"},  int'(pixel_out), exp);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    int t0, t_last, t_done, ndone, nwr, exp_a, exp_issue, lat0;
    int bad_pix, bad_addr, bad_seq, k2;

    initial begin
        rst_in   = 1'b1;
        start_in = 1'b0;
        mode_in  = 2'b00;
        pat      = pat9(10, 10, 10, 10, 10, 10, 10, 10, 10);
        #1;
        chk("rst_addr",  int'(addr_out), 0);
        chk("rst_paddr", int'(pixel_addr_out), 0);
        chk("rst_pix",   int'(pixel_out), 0);
        chk("rst_valid", int'(pixel_valid_out), 0);
        chk("rst_busy",  int'(busy_out), 0);
        chk("rst_done",  int'(done_out), 0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("idle_busy", int'(busy_out), 0);

        // Full scan, all f=10, density; a stray start with a new mode arrives mid-scan
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        t0 = cyc;
        chk("scan_busy",  int'(busy_out), 1);
        chk("scan_addr0", int'(addr_out), 0);
        exp_a = 0; nwr = 0; bad_pix = 0; bad_addr = 0; bad_seq = 0;
        lat0 = -1; t_last = -1; t_done = -1; ndone = 0;
        for (int k = 0; k < BUDGET && t_done < 0; k++) begin
            @(negedge clk_in);
            start_in = 1'b0;
            mode_in  = 2'b00;
            if (pixel_valid_out) begin
                if (pixel_out != 8'd11) bad_pix++;
                if (int'(pixel_addr_out) != exp_a) bad_addr++;
                if (exp_a == 0) lat0 = cyc - t0;
                exp_a++;
                nwr++;
            end
            exp_issue = (cyc - t0 > LAST) ? LAST : cyc - t0;
            if (busy_out && int'(addr_out) != exp_issue) bad_seq++;
            if (int'(addr_out) == LAST && t_last < 0) t_last = cyc;
            if (done_out) begin
                t_done = cyc;
                ndone++;
            end
            if (nwr == 500) begin
                start_in = 1'b1;
                mode_in  = 2'b11;
            end
        end
        chk("scan_done_seen", int'(t_done >= 0), 1);
        chk("scan_writes",    nwr, DEPTH);
        chk("scan_bad_pix",   bad_pix, 0);
        chk("scan_bad_paddr", bad_addr, 0);
        chk("scan_bad_issue", bad_seq, 0);
        chk("scan_lat_first", lat0, 4);
        chk("scan_lat_done",  t_done - t_last, 5);
        chk("done_busy",      int'(busy_out), 0);
        // start in the done cycle must be ignored
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("after_done",      int'(done_out), 0);
        chk("after_done_busy", int'(busy_out), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            if (done_out) ndone++;
        end
        chk("ignored_start_busy", int'(busy_out), 0);
        chk("done_pulses",        ndone, 1);

        // Arithmetic and clamping on the first pixel of short scans
        probe("all8_rho",   pat9(8, 8, 8, 8, 8, 8, 8, 8, 8), 2'b00, 9);
        probe("all8_ux",    pat9(8, 8, 8, 8, 8, 8, 8, 8, 8), 2'b01, 128);
        probe("east_ux",    pat9(0, 0, 127, 127, 127, 0, 0, 0, 0), 2'b01, 223);
        probe("east_uy",    pat9(0, 0, 127, 127, 127, 0, 0, 0, 0), 2'b10, 128);
        probe("east_spd",   pat9(0, 0, 127, 127, 127, 0, 0, 0, 0), 2'b11, 95);
        probe("north_uy",   pat9(0, 200, 0, 0, 0, 0, 0, 0, 0), 2'b10, 178);
        probe("north_spd",  pat9(0, 200, 0, 0, 0, 0, 0, 0, 0), 2'b11, 50);
        probe("south_uy",   pat9(0, 0, 0, 0, 0, 100, 0, 0, 0), 2'b10, 103);
        probe("south_spd",  pat9(0, 0, 0, 0, 0, 100, 0, 0, 0), 2'b11, 25);
        probe("west1_ux",   pat9(0, 0, 0, 0, 0, 0, 0, 1, 0), 2'b01, 127);
        probe("sat_rho",    pat9(255, 255, 255, 255, 255, 255, 255, 255, 255), 2'b00, 255);
        probe("west_ux",    pat9(0, 0, 0, 0, 0, 0, 255, 255, 255), 2'b01, 0);
        probe("south_uy0",  pat9(0, 0, 0, 0, 255, 255, 255, 0, 0), 2'b10, 0);
        probe("ne_spd_max", pat9(0, 255, 255, 255, 0, 0, 0, 0, 0), 2'b11, 255);

        // Reset in the middle of a scan
        pat     = pat9(10, 10, 10, 10, 10, 10, 10, 10, 10);
        mode_in = 2'b00;
        repeat (3) @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        k2 = 0;
        while (int'(addr_out) != 1000 && k2 < 1100) begin
            @(negedge clk_in);
            k2++;
        end
        chk("abort_reach_1000", int'(addr_out), 1000);
        rst_in = 1'b1;
        #1;
        chk("abort_addr",  int'(addr_out), 0);
        chk("abort_paddr", int'(pixel_addr_out), 0);
        chk("abort_pix",   int'(pixel_out), 0);
        chk("abort_valid", int'(pixel_valid_out), 0);
        chk("abort_busy",  int'(busy_out), 0);
        chk("abort_done",  int'(done_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        ndone = 0;
        nwr   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (done_out) ndone++;
            if (pixel_valid_out) nwr++;
        end
        chk("abort_no_done",   ndone, 0);
        chk("abort_no_pixels", nwr, 0);

        // Fresh scan after the abort restarts from address 0
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("fresh_addr0", int'(addr_out), 0);
        chk("fresh_busy",  int'(busy_out), 1);
        repeat (3) @(negedge clk_in);
        chk("fresh_addr3", int'(addr_out), 3);
        @(negedge clk_in);
        chk("fresh_valid", int'(pixel_valid_out), 1);
        chk("fresh_paddr", int'(pixel_addr_out), 0);
        chk("fresh_pix",   int'(pixel_out), 11);
        @(negedge clk_in);
        chk("fresh_paddr1", int'(pixel_addr_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
